// File: rtl/dds_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// dds_cfg_arbiter
//
// Shares one DDS configuration AXI4-Stream master port between NUM_CH
// parallel-bus requesters (for example per-receiver phase-increment words).
// Every channel word is snapshotted each cycle. A word that differs from its
// snapshot marks that channel pending. Pending channels are granted in
// round-robin order. Each grant emits one beat carrying the snapshotted word,
// with the channel index on tuser.
//
// Optional feature (compile-time macro DDSARB_FORCE_UPDATE_EN):
//   defined   -> the force_update input exists. A one-cycle pulse marks every
//                channel pending, so a full reload can follow a DDS reset.
//   undefined -> the port is absent. Pending is set only by change detection.
//
// Parameters:
//   DIN_WIDTH  width of each channel word and of m_axis_tdata
//   NUM_CH     number of requesters (2..16)
//   CHW        channel index width, 2**CHW >= NUM_CH
//
// Ports:
//   aclk           in   clock, all logic on the rising edge
//   aresetn        in   asynchronous active-low reset
//   data_in        in   packed channel words, channel i = [i*DIN_WIDTH +: DIN_WIDTH]
//   force_update   in   mark all channels pending (macro builds only)
//   m_axis_tready  in   downstream ready
//   m_axis_tdata   out  granted channel word (registered)
//   m_axis_tuser   out  granted channel index (registered)
//   m_axis_tvalid  out  beat valid (registered)
//   pending        out  per-channel pending flags
// -----------------------------------------------------------------------------
module dds_cfg_arbiter #(
    parameter int DIN_WIDTH = 32,
    parameter int NUM_CH    = 4,
    parameter int CHW       = 2
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [NUM_CH*DIN_WIDTH-1:0] data_in,
`ifdef DDSARB_FORCE_UPDATE_EN
    input  logic                        force_update,
`endif
    input  logic                        m_axis_tready,
    output logic [DIN_WIDTH-1:0]        m_axis_tdata,
    output logic [CHW-1:0]              m_axis_tuser,
    output logic                        m_axis_tvalid,
    output logic [NUM_CH-1:0]           pending
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);

    state_t                            state;
    state_t                            state_n;

    logic [NUM_CH-1:0][DIN_WIDTH-1:0]  snapshot;
    logic [NUM_CH-1:0]                 changed;
    logic [NUM_CH-1:0]                 force_vec;

    logic [NUM_CH-1:0]                 pending_q;
    logic [NUM_CH-1:0]                 pending_n;
    logic [NUM_CH-1:0]                 grant_mask;

    logic [CHW-1:0]                    last_grant;
    logic [CHW-1:0]                    last_grant_n;
    logic [CHW-1:0]                    cand;
    logic [CHW-1:0]                    pick_idx;
    logic                              pick_found;
    logic                              do_grant;

    logic [DIN_WIDTH-1:0]              tdata_q;
    logic [DIN_WIDTH-1:0]              tdata_n;
    logic [CHW-1:0]                    tuser_q;
    logic [CHW-1:0]                    tuser_n;
    logic                              tvalid_q;
    logic                              tvalid_n;

    // -------------------------------------------------------------------------
    // Per-channel snapshot and change detect
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIN_WIDTH-1:0] snap_q;

        assign changed[i]  = (data_in[i*DIN_WIDTH +: DIN_WIDTH] != snap_q);
        assign snapshot[i] = snap_q;

        // NOTE: this storage is reset, unlike a typical data array. A zero
        // snapshot is the comparison baseline, so a nonzero word held through
        // reset release is seen as a change on the first clock.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                snap_q <= '0;
            end else if (changed[i]) begin
                snap_q <= data_in[i*DIN_WIDTH +: DIN_WIDTH];
            end
        end
    end

`ifdef DDSARB_FORCE_UPDATE_EN
    assign force_vec = {NUM_CH{force_update}};
`else
    assign force_vec = '0;
`endif

    // -------------------------------------------------------------------------
    // Round-robin pick: first pending channel above last_grant, wrapping.
    // Offset NUM_CH wraps back to last_grant itself, so the channel served
    // most recently has the lowest priority.
    // -------------------------------------------------------------------------
    // NOTE: every variable assigned in a combinational block gets a default
    // on entry, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            cand = CHW'((int'(last_grant) + off) % NUM_CH);
            if (!pick_found && pending_q[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and registered outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_n      = state;
        tdata_n      = tdata_q;
        tuser_n      = tuser_q;
        tvalid_n     = tvalid_q;
        last_grant_n = last_grant;
        do_grant     = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    do_grant = 1'b1;
                end
            end
            SEND: begin
                // The beat is held until it is accepted. On acceptance the
                // next grant is loaded in the same cycle so beats stream
                // back to back.
                if (tvalid_q && m_axis_tready) begin
                    if (pick_found) begin
                        do_grant = 1'b1;
                    end else begin
                        tvalid_n = 1'b0;
                        state_n  = IDLE;
                    end
                end
            end
            default: begin
                state_n  = IDLE;
                tvalid_n = 1'b0;
            end
        endcase

        if (do_grant) begin
            // The registered snapshot is sent. A change arriving in this
            // same cycle updates the snapshot and goes out on a later grant.
            tdata_n      = snapshot[pick_idx];
            tuser_n      = pick_idx;
            tvalid_n     = 1'b1;
            last_grant_n = pick_idx;
            state_n      = SEND;
        end

        grant_mask = do_grant ? (NUM_CH'(1) << pick_idx) : '0;
        // The set terms are applied after the grant clear, so a change in the
        // grant cycle keeps the channel pending.
        pending_n  = (pending_q & ~grant_mask) | changed | force_vec;
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pending_q  <= '0;
            last_grant <= LAST_CH;
            tdata_q    <= '0;
            tuser_q    <= '0;
            tvalid_q   <= 1'b0;
        end else begin
            pending_q  <= pending_n;
            last_grant <= last_grant_n;
            tdata_q    <= tdata_n;
            tuser_q    <= tuser_n;
            tvalid_q   <= tvalid_n;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_dds_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for dds_cfg_arbiter with default parameters (32-bit words, 4 channels).
// A directed vector table covers reset, first grant, burst ordering and
// backpressure. Hand sequences cover the grant-cycle change, a mid-beat reset
// and (macro builds) force_update. A randomized phase compares the DUT with a
// per-cycle behavioural model built from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_dds_cfg_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int CW = 2;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [W-1:0]    din [N];
    logic [N*W-1:0]  data_in;
`ifdef DDSARB_FORCE_UPDATE_EN
    logic            force_update = 1'b0;
`endif
    logic            tready = 1'b1;
    logic [W-1:0]    tdata;
    logic [CW-1:0]   tuser;
    logic            tvalid;
    logic [N-1:0]    pending;

    assign data_in = {din[3], din[2], din[1], din[0]};

    always #5 aclk = ~aclk;

    dds_cfg_arbiter #(
        .DIN_WIDTH (W),
        .NUM_CH    (N),
        .CHW       (CW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .data_in       (data_in),
`ifdef DDSARB_FORCE_UPDATE_EN
        .force_update  (force_update),
`endif
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tuser  (tuser),
        .m_axis_tvalid (tvalid),
        .pending       (pending)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: one call per clock edge, with the inputs that are
    // present before that edge.
    // -------------------------------------------------------------------------
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_user;
    bit           m_pend [N];
    logic [W-1:0] m_snap [N];
    int           m_last;

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_user  = 0;
        m_last  = N - 1;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_snap[i] = '0;
        end
    endtask

    task automatic model_step(input bit frc);
        int g;
        int c;
        bit hs;
        g  = -1;
        hs = m_valid && tready;
        if (!m_valid || hs) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        if (g >= 0) begin
            m_valid   = 1'b1;
            m_data    = m_snap[g];
            m_user    = g;
            m_pend[g] = 1'b0;
            m_last    = g;
        end else if (hs) begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (din[i] !== m_snap[i]) begin
                m_snap[i] = din[i];
                m_pend[i] = 1'b1;
            end
            if (frc) m_pend[i] = 1'b1;
        end
    endtask

    function automatic logic [N-1:0] model_pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // -------------------------------------------------------------------------
    // Directed vector table: inputs applied at a falling edge, outputs checked
    // at the next falling edge.
    // -------------------------------------------------------------------------
    typedef struct {
        bit            rst_n;
        logic [W-1:0]  d0, d1, d2, d3;
        bit            rdy;
        bit            ev;
        logic [W-1:0]  edata;
        logic [CW-1:0] euser;
        logic [N-1:0]  epend;
    } vec_t;

    vec_t vecs [$];

    task automatic add_row(input bit r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d, input bit rdy,
                           input bit ev, input logic [W-1:0] ed, input logic [CW-1:0] eu,
                           input logic [N-1:0] ep);
        vec_t v;
        v.rst_n = r; v.d0 = a; v.d1 = b; v.d2 = c; v.d3 = d; v.rdy = rdy;
        v.ev = ev; v.edata = ed; v.euser = eu; v.epend = ep;
        vecs.push_back(v);
    endtask

    typedef struct {
        logic [CW-1:0] user;
        logic [W-1:0]  data;
    } beat_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t beats [$];
        vec_t  v;
        bit    frc;

        // ---------------- reset state ----------------
        for (int i = 0; i < N; i++) din[i] = '0;
        aresetn = 1'b0;
        tready  = 1'b1;
        repeat (3) cycle();
        check("reset tvalid", tvalid, 0);
        check("reset tdata", tdata, 0);
        check("reset tuser", tuser, 0);
        check("reset pending", pending, 0);
        aresetn = 1'b1;

        // All inputs zero: nothing may be requested.
        for (int i = 0; i < 20; i++) begin
            cycle();
            check($sformatf("idle%0d tvalid", i), tvalid, 0);
            check($sformatf("idle%0d pending", i), pending, 0);
        end

        // ---------------- vector table ----------------
        // First request: ch2 changes, tvalid two edges later.
        add_row(1, 0, 0, 32'h1234, 0, 1, 0, 0,          0, 4'h4);
        add_row(1, 0, 0, 32'h1234, 0, 1, 1, 32'h1234,   2, 4'h0);
        add_row(1, 0, 0, 32'h1234, 0, 1, 0, 0,          0, 4'h0);
        // Reset, then three channels change together under backpressure.
        add_row(0, 0, 0, 0, 0, 0,                   0, 0,    0, 4'h0);
        add_row(1, 32'hA, 32'hB, 0, 32'hD, 0,       0, 0,    0, 4'hB);
        add_row(1, 32'hA, 32'hB, 0, 32'hD, 0,       1, 32'hA, 0, 4'hA);
        for (int i = 0; i < 10; i++)
            add_row(1, 32'hA, 32'hB, 0, 32'hD, 0,   1, 32'hA, 0, 4'hA);
        // Ready rises: remaining beats stream without bubbles.
        add_row(1, 32'hA, 32'hB, 0, 32'hD, 1,       1, 32'hB, 1, 4'h8);
        add_row(1, 32'hA, 32'hB, 0, 32'hD, 1,       1, 32'hD, 3, 4'h0);
        add_row(1, 32'hA, 32'hB, 0, 32'hD, 1,       0, 0,    0, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            v       = vecs[i];
            aresetn = v.rst_n;
            din[0]  = v.d0;
            din[1]  = v.d1;
            din[2]  = v.d2;
            din[3]  = v.d3;
            tready  = v.rdy;
            cycle();
            check($sformatf("vec%0d tvalid", i), tvalid, v.ev);
            if (v.ev)
                check($sformatf("vec%0d tuser/tdata", i), {tuser, tdata}, {v.euser, v.edata});
            check($sformatf("vec%0d pending", i), pending, v.epend);
        end

        // ---------------- change in the grant cycle ----------------
        din[1] = 32'h5;
        cycle();
        check("gc pending set", pending, 4'h2);
        din[1] = 32'h6;
        cycle();
        check("gc beat1 tvalid", tvalid, 1);
        check("gc beat1 tuser/tdata", {tuser, tdata}, {2'd1, 32'h5});
        check("gc beat1 pending kept", pending, 4'h2);
        cycle();
        check("gc beat2 tvalid", tvalid, 1);
        check("gc beat2 tuser/tdata", {tuser, tdata}, {2'd1, 32'h6});
        check("gc beat2 pending", pending, 4'h0);
        cycle();
        check("gc drain tvalid", tvalid, 0);

        // ---------------- reset in the middle of a beat ----------------
        tready = 1'b0;
        din[0] = 32'h77;
        cycle();
        cycle();
        check("mid beat tvalid", tvalid, 1);
        check("mid beat tuser/tdata", {tuser, tdata}, {2'd0, 32'h77});
        din[3] = 32'h99;
        cycle();
        check("mid pending", pending, 4'h8);
        #2;
        aresetn = 1'b0;
        for (int i = 0; i < N; i++) din[i] = '0;
        #1;
        check("async reset tvalid", tvalid, 0);
        check("async reset pending", pending, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        tready  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check($sformatf("post reset%0d tvalid", i), tvalid, 0);
        end
        check("post reset pending", pending, 0);

`ifdef DDSARB_FORCE_UPDATE_EN
        // ---------------- force update ----------------
        for (int i = 0; i < N; i++) din[i] = W'(i + 1);
        repeat (8) cycle();
        check("force pre tvalid", tvalid, 0);
        check("force pre pending", pending, 0);
        force_update = 1'b1;
        cycle();
        force_update = 1'b0;
        check("force pending", pending, 4'hF);
        beats.delete();
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (tvalid) begin
                beat_t b;
                b.user = tuser;
                b.data = tdata;
                beats.push_back(b);
            end
        end
        check("force beat count", beats.size(), 4);
        for (int i = 0; i < N; i++) begin
            if (i < beats.size())
                check($sformatf("force beat%0d", i), {beats[i].user, beats[i].data},
                      {CW'(i), W'(i + 1)});
        end
`endif

        // ---------------- randomized against the model ----------------
        aresetn = 1'b0;
        for (int i = 0; i < N; i++) din[i] = '0;
        tready = 1'b1;
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) din[i] = W'($urandom_range(0, 3));
            tready = ($urandom_range(0, 9) < 7);
            frc = 1'b0;
`ifdef DDSARB_FORCE_UPDATE_EN
            frc = ($urandom_range(0, 19) == 0);
            force_update = frc;
`endif
            model_step(frc);
            cycle();
            check($sformatf("rnd%0d tvalid", t), tvalid, m_valid);
            if (m_valid)
                check($sformatf("rnd%0d tuser/tdata", t), {tuser, tdata}, {CW'(m_user), m_data});
            check($sformatf("rnd%0d pending", t), pending, model_pend_vec());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_cfg_arbiter.md
# dds_cfg_arbiter

Shares one DDS configuration AXI4-Stream port between NUM_CH parallel-bus requesters, such as per-receiver phase-increment words. Each channel's bus is snapshotted and monitored for change. A changed value is queued as pending, and pending channels are granted round-robin. Each grant emits one AXI4-Stream beat tagged with the channel index. The block sits between the register/control bus outputs and a multi-channel DDS config slave.

## Interface
- DIN_WIDTH, 32, width of each channel word and of m_axis_tdata
- NUM_CH, 4, number of requesters (2..16)
- CHW, 2, channel index width; must satisfy 2^CHW >= NUM_CH
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- data_in  in  NUM_CH*DIN_WIDTH  packed channel words; channel i = bits [i*DIN_WIDTH +: DIN_WIDTH]
- force_update  in  1  single-cycle pulse; marks all channels pending (present only with DDSARB_FORCE_UPDATE_EN)
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  DIN_WIDTH  granted channel word
- m_axis_tuser  out  CHW  granted channel index
- m_axis_tvalid  out  1  beat valid
- pending  out  NUM_CH  per-channel pending flags (status)

## Operation
- Reset, asynchronous on aresetn=0:
  - snapshot[i]=0, pending=0, last_grant=NUM_CH-1
  - state=IDLE, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0
- Change detect, every cycle, each channel i: if data_in slice i != snapshot[i], then snapshot[i] <= slice and pending[i] <= 1.
  - A nonzero input held through reset release becomes pending on the first clock after release.
- Round-robin pick: the first pending channel searching upward from last_grant+1, with modulo NUM_CH wrap.
- State IDLE:
  - If any pending bit is set: load tdata=snapshot[g] (the registered value, pre-update), tuser=g, tvalid=1, clear pending[g], last_grant<=g; go to SEND.
  - Otherwise stay in IDLE with tvalid=0.
- State SEND:
  - tdata and tuser are held stable while tvalid=1 and tready=0.
  - On a handshake (tvalid & tready), if another channel is pending: perform an IDLE-style grant in the same cycle and stay in SEND, so back-to-back beats have no bubble.
  - On a handshake with no other channel pending: tvalid<=0, go to IDLE.
- Simultaneous set and clear on the same channel (change detected in its grant cycle):
  - Set wins; pending[g] stays 1.
  - The old snapshot is sent now, and the new value is sent on a later grant.
- Multiple changes on one channel while it is pending coalesce: only the latest value is sent.
- tvalid never drops without a handshake, except on reset.

## Timing
- Latency, data_in change to tvalid with the arbiter idle: 2 cycles (cycle 1 snapshot/pending, cycle 2 tvalid high).
- Throughput: 1 beat/cycle while tready=1 and requests are outstanding.
- Worst-case wait for a pending channel: NUM_CH-1 grants.
- Reset mid-beat: tvalid drops immediately (asynchronously) and all pending requests are lost.
- All outputs are registered; there is no combinational path from tready to outputs.

## Configuration
- DDSARB_FORCE_UPDATE_EN defined:
  - The force_update port exists.
  - A high cycle sets all pending bits on the next edge, ORed with change detection. This allows a full DDS reload after a DDS reset.
- Not defined: the port is absent and pending is set only by change detection.

## Test plan
- Reset, all data_in=0, tready=1 → tvalid stays 0 and pending=0 for 20 cycles. Then set ch2=0x0000_1234 → tvalid=1 two cycles later with tdata=0x0000_1234, tuser=2; pending[2] clears on grant.
- With tready=0, change ch0=0xA, ch1=0xB and ch3=0xD in the same cycle, then raise tready → beats issued in order tuser 0,1,3 with tdata A,B,D on consecutive cycles, no bubbles.
- Backpressure: hold tready=0 for 10 cycles during a beat → tdata and tuser remain stable, and tvalid remains 1.
- Change ch1 to 0x5 then 0x6 on the grant cycle of ch1 → beat with tdata 0x5, followed by a later beat with tuser=1, tdata=0x6.
- Assert aresetn=0 mid-beat → tvalid=0 immediately and pending=0. After release, inputs unchanged from reset (zero) → no beats.
- With DDSARB_FORCE_UPDATE_EN, data ch0..3 = 1,2,3,4 already sent, pulse force_update → four beats, tuser 0..3 round-robin from last_grant+1, tdata 1..4.
